// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and data memory (slave).
// Request fields are held stable while mem_req is high; mem_rdata is valid with mem_ready.
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store stage: decodes width/alignment, drives a handshaked
// bus with a timeout, and returns sign/zero-extended load data one cycle after completion.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        access_fault,
   output logic        bus_error,
   load_store_unit_if.master mem
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        bus_error_q, bus_error_d;

   logic        legal, misaligned, fault;
   logic [3:0]  be_dec;
   logic [31:0] wdata_dec;
   logic [31:0] rd_shift;
   logic [31:0] rd_ext;

   // Request decode: legality, alignment, lane enables and store replication.
   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      be_dec     = 4'b1111;
      wdata_dec  = req_wdata;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !req_write;
         default:                legal = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'b00: begin
            be_dec    = 4'b0001 << req_addr[1:0];
            wdata_dec = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = req_addr[0];
            be_dec     = 4'b0011 << req_addr[1:0];
            wdata_dec  = {2{req_wdata[15:0]}};
         end
         default: misaligned = (req_addr[1:0] != 2'b00);
      endcase
      fault = !legal || misaligned;
   end

   always_comb begin
      rd_shift = mem.mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  rd_ext = {24'b0, rd_shift[7:0]};
         3'b101:  rd_ext = {16'b0, rd_shift[15:0]};
         default: rd_ext = mem.mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      off_d        = off_q;
      f3_d         = f3_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      bus_error_d  = 1'b0;
      stall        = 1'b0;
      access_fault = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (fault) begin
                  access_fault = 1'b1;
               end else begin
                  stall       = 1'b1;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_write;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = be_dec;
                  mem_wdata_d = wdata_dec;
                  off_d       = req_addr[1:0];
                  f3_d        = req_funct3;
                  cnt_d       = '0;
                  state_d     = BUS;
               end
            end
         end
         BUS: begin
            stall = 1'b1;
            // mem_ready takes priority over a timeout firing in the same cycle
            if (mem.mem_ready) begin
               load_data_d  = mem_we_q ? 32'h0 : rd_ext;
               load_valid_d = !mem_we_q;
               mem_req_d    = 1'b0;
               state_d      = RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               cnt_d       = cnt_q + CW'(1);
               bus_error_d = 1'b1;
               load_data_d = 32'h0;
               mem_req_d   = 1'b0;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (rst) begin
         stall        = 1'b0;
         access_fault = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_be_q     <= 4'h0;
         off_q        <= 2'b00;
         f3_q         <= 3'b000;
         load_data_q  <= 32'h0;
         load_valid_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         off_q        <= off_d;
         f3_q         <= f3_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         bus_error_q  <= bus_error_d;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_be    = mem_be_q;
   assign load_data     = load_data_q;
   assign load_valid    = load_valid_q;
   assign bus_error     = bus_error_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory access stage directly downstream of the CPU's ALU/address path. It replaces the single-cycle data-memory hookup with a handshaked bus master.
- Accepts one load/store per instruction (address = rs1+imm, data = rs2, funct3) and stalls the core until the access completes.
- Handles sub-word lanes: byte enables, store replication, load sign/zero extension.
- Flags misaligned and illegal accesses, and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUS waiting for mem_ready before bus_error; counter width $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  current instruction is a load or store
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold PC and regfile write; combinational
- load_data  out  32  extended load result, registered
- load_valid  out  1  load result valid (RESP cycle of a good load)
- access_fault  out  1  misaligned or illegal funct3; combinational, IDLE only
- bus_error  out  1  timeout on the current access, registered
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus completes access this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1

Behaviour:
- Reset values: every registered output is 0; state = IDLE; timeout counter = 0. stall = 0 while rst=1.
- States: IDLE, BUS, RESP.
- Supported funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Fault conditions:
  - Illegal: any other funct3 code, including store codes 1xx.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- IDLE, req_valid=1 and fault:
  - access_fault=1 and stall=0 that cycle.
  - No bus access; state stays IDLE. The core squashes writeback.
- IDLE, req_valid=1 and legal:
  - stall=1.
  - On the clock edge, register mem_req=1, mem_we=req_write, mem_addr, mem_be, mem_wdata, plus the byte offset and funct3.
  - Clear the counter; go to BUS.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: 4'b0011<<addr[1:0].
  - SW/LW: 4'b1111.
- Store data: SB replicates byte ×4; SH replicates halfword ×2; SW passes the word through.
- BUS:
  - stall=1; mem_req and all bus fields held stable.
  - mem_ready=1: capture the extracted and extended load data into load_data (0 for stores); mem_req←0; go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT_CYCLES with mem_ready=0: bus_error←1, load_data←0, mem_req←0; go to RESP.
  - mem_ready seen on the same cycle the timeout would fire: mem_ready wins, no error.
- RESP:
  - stall=0; load_valid=1 iff the access was a load and bus_error=0. bus_error is held for this cycle.
  - The core retires the instruction on this edge.
  - req_valid is ignored in RESP (same instruction). Next state is IDLE, where load_valid and bus_error clear.
- Load extraction: select byte/halfword by the stored offset; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency: at minimum, 3 cycles per access (IDLE accept, BUS with immediate mem_ready, RESP). Each wait state adds 1.
- Reset mid-operation: rst=1 in BUS or RESP gives IDLE and all outputs 0 after the edge. The abandoned request is dropped; the bus must tolerate mem_req deasserting without mem_ready.
- mem_ready outside BUS is ignored.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready=1 in first BUS cycle -> stall high 2 cycles, mem_be=1111, load_data=0xDEADBEEF, load_valid=1 in RESP.
- LB addr 0x103, mem_rdata 0x80FF_0000, 2 wait states -> mem_be=1000, load_data=0xFFFFFF80, stall 4 cycles. Same with LBU -> 0x00000080.
- SH addr 0x202, req_wdata 0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, load_valid=0 in RESP.
- LW addr 0x101, then SH addr 0x3 -> access_fault=1, stall=0, mem_req stays 0. funct3=011 load -> access_fault=1.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> bus_error=1 in RESP, load_data=0, load_valid=0. mem_ready=1 in the final count cycle -> no error.
- rst asserted during second BUS cycle -> next cycle mem_req=0, state IDLE, stall=0. A following LW completes normally.
